// File: rtl/pim_dma_pkg.sv
// ----------------------------------------------------------------------------
// pim_dma_pkg -- shared types and constants for the PIM DMA engine. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package pim_dma_pkg;

  localparam int PIM_AW = 11;
  localparam int CNT_W  = 11;

  localparam logic [2:0] DMA_M2P = 3'b000;
  localparam logic [2:0] DMA_P2M = 3'b001;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    M_RD = 3'd1,
    P_WR = 3'd2,
    P_RD = 3'd3,
    M_WR = 3'd4,
    DONE = 3'd5
  } state_e;

endpackage

`default_nettype wire

// File: rtl/pim_dma_if.sv
// ----------------------------------------------------------------------------
// pim_dma_if -- command, memory and PIM signal bundle of pim_dma; stats port
// present only with PIM_DMA_STATS_EN. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface pim_dma_if;
  import pim_dma_pkg::*;

  logic              dma_en_i;
  logic [2:0]        dma_funct3_i;
  logic [3:0]        dma_sel_pim_i;
  logic [12:0]       dma_size_i;
  logic [31:0]       dma_mem_addr_i;
  logic              dma_busy_o;

  logic              mem_req_o;
  logic              mem_gnt_i;
  logic [31:0]       mem_addr_o;
  logic [31:0]       mem_wr_data_o;
  logic [31:0]       mem_rd_data_i;
  logic [3:0]        mem_size_o;
  logic              mem_read_o;
  logic              mem_write_o;

  logic [3:0]        pim_sel_o;
  logic              pim_req_o;
  logic              pim_ready_i;
  logic              pim_we_o;
  logic [PIM_AW-1:0] pim_addr_o;
  logic [31:0]       pim_wr_data_o;
  logic [31:0]       pim_rd_data_i;

`ifdef PIM_DMA_STATS_EN
  logic [15:0]       dma_done_cnt_o;
`endif

  modport master (
    input  dma_en_i, dma_funct3_i, dma_sel_pim_i, dma_size_i, dma_mem_addr_i,
    output dma_busy_o,
    output mem_req_o, mem_addr_o, mem_wr_data_o, mem_size_o, mem_read_o, mem_write_o,
    input  mem_gnt_i, mem_rd_data_i,
    output pim_sel_o, pim_req_o, pim_we_o, pim_addr_o, pim_wr_data_o,
    input  pim_ready_i, pim_rd_data_i
`ifdef PIM_DMA_STATS_EN
    , output dma_done_cnt_o
`endif
  );

  modport slave (
    output dma_en_i, dma_funct3_i, dma_sel_pim_i, dma_size_i, dma_mem_addr_i,
    input  dma_busy_o,
    input  mem_req_o, mem_addr_o, mem_wr_data_o, mem_size_o, mem_read_o, mem_write_o,
    output mem_gnt_i, mem_rd_data_i,
    input  pim_sel_o, pim_req_o, pim_we_o, pim_addr_o, pim_wr_data_o,
    output pim_ready_i, pim_rd_data_i
`ifdef PIM_DMA_STATS_EN
    , input dma_done_cnt_o
`endif
  );

endinterface

`default_nettype wire

// File: rtl/pim_dma.sv
// ----------------------------------------------------------------------------
// pim_dma -- word-granular DMA between system memory and one-hot selected PIM
// banks; PIM_DMA_STATS_EN adds a completed-transfer counter. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pim_dma
  import pim_dma_pkg::*;
(
  input  logic      clk_i,
  input  logic      rst_ni,
  pim_dma_if.master bus
);

  state_e            state_q, state_d;
  logic [29:0]       mem_word_q;
  logic [PIM_AW-1:0] pim_addr_q;
  logic [CNT_W-1:0]  remain_q;
  logic [31:0]       data_q;
  logic [3:0]        sel_q;
  logic              rd_pend_q;

  logic [CNT_W-1:0]  words;
  logic              cmd_ok;
  logic              load, advance, set_pend, cap_mem, cap_pim;
  logic              mem_req, mem_read, mem_write, pim_req, pim_we;
  logic              size_unused;

  assign words       = bus.dma_size_i[12:2];
  assign cmd_ok      = ((bus.dma_funct3_i == DMA_M2P) || (bus.dma_funct3_i == DMA_P2M)) &&
                       (words != '0);
  assign size_unused = ^{bus.dma_size_i[1:0], bus.dma_mem_addr_i[1:0]};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Read data lands one cycle after the grant, so P_WR spends that cycle
  // capturing it before presenting the write to the PIM bank.
  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    advance   = 1'b0;
    set_pend  = 1'b0;
    cap_mem   = 1'b0;
    cap_pim   = 1'b0;
    mem_req   = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    pim_req   = 1'b0;
    pim_we    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.dma_en_i && cmd_ok) begin
          load    = 1'b1;
          state_d = (bus.dma_funct3_i == DMA_M2P) ? M_RD : P_RD;
        end
      end
      M_RD: begin
        mem_req  = 1'b1;
        mem_read = 1'b1;
        if (bus.mem_gnt_i) begin
          set_pend = 1'b1;
          state_d  = P_WR;
        end
      end
      P_WR: begin
        if (rd_pend_q) begin
          cap_mem = 1'b1;
        end else begin
          pim_req = 1'b1;
          pim_we  = 1'b1;
          advance = bus.pim_ready_i;
        end
      end
      P_RD: begin
        pim_req = 1'b1;
        if (bus.pim_ready_i) begin
          cap_pim = 1'b1;
          state_d = M_WR;
        end
      end
      M_WR: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        advance   = bus.mem_gnt_i;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (advance) begin
      if (remain_q == CNT_W'(1)) state_d = DONE;
      else                       state_d = (state_q == P_WR) ? M_RD : P_RD;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_word_q <= '0;
      pim_addr_q <= '0;
      remain_q   <= '0;
      data_q     <= '0;
      sel_q      <= '0;
      rd_pend_q  <= 1'b0;
    end else begin
      if (load) begin
        mem_word_q <= bus.dma_mem_addr_i[31:2];
        pim_addr_q <= '0;
        remain_q   <= words;
        sel_q      <= bus.dma_sel_pim_i;
        rd_pend_q  <= 1'b0;
      end
      if (set_pend) rd_pend_q <= 1'b1;
      if (cap_mem) begin
        data_q    <= bus.mem_rd_data_i;
        rd_pend_q <= 1'b0;
      end
      if (cap_pim) data_q <= bus.pim_rd_data_i;
      if (advance) begin
        mem_word_q <= mem_word_q + 30'd1;
        pim_addr_q <= pim_addr_q + PIM_AW'(1);
        remain_q   <= remain_q - CNT_W'(1);
      end
      if (state_q == DONE) sel_q <= '0;
    end
  end

  assign bus.dma_busy_o    = (state_q != IDLE);
  assign bus.mem_req_o     = mem_req;
  assign bus.mem_read_o    = mem_read;
  assign bus.mem_write_o   = mem_write;
  assign bus.mem_size_o    = mem_req ? 4'b1111 : 4'b0000;
  assign bus.mem_addr_o    = {mem_word_q, 2'b00};
  assign bus.mem_wr_data_o = data_q;
  assign bus.pim_sel_o     = sel_q;
  assign bus.pim_req_o     = pim_req;
  assign bus.pim_we_o      = pim_we;
  assign bus.pim_addr_o    = pim_addr_q;
  assign bus.pim_wr_data_o = data_q;

`ifdef PIM_DMA_STATS_EN
  logic [15:0] done_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)               done_cnt_q <= '0;
    else if (state_q == DONE)  done_cnt_q <= done_cnt_q + 16'd1;
  end

  assign bus.dma_done_cnt_o = done_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pim_dma.sv
// ----------------------------------------------------------------------------
// tb_pim_dma -- directed self-checking bench for pim_dma. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_pim_dma;
  import pim_dma_pkg::*;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  pim_dma_if bus ();

  pim_dma dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  // Memory and PIM return data derived from the address being accessed.
  assign bus.mem_rd_data_i = bus.mem_addr_o ^ 32'hDEAD_0000;
  assign bus.pim_rd_data_i = 32'hCAFE_0000 | {21'd0, bus.pim_addr_o};

  int compared   = 0;
  int mismatched = 0;

  logic [31:0] mrd_q[$];
  logic [31:0] mwr_a_q[$];
  logic [31:0] mwr_d_q[$];
  logic [31:0] pwr_a_q[$];
  logic [31:0] pwr_d_q[$];
  logic [31:0] prd_a_q[$];
  logic [3:0]  psel_q[$];
  int busy_cyc, overlap, bad_size;

  always @(negedge clk_i) begin
    if (bus.dma_busy_o) busy_cyc++;
    if (bus.mem_req_o && bus.pim_req_o) overlap++;
    if (bus.mem_req_o && bus.mem_gnt_i) begin
      if (bus.mem_size_o != 4'b1111) bad_size++;
      if (bus.mem_read_o) mrd_q.push_back(bus.mem_addr_o);
      if (bus.mem_write_o) begin
        mwr_a_q.push_back(bus.mem_addr_o);
        mwr_d_q.push_back(bus.mem_wr_data_o);
      end
    end
    if (bus.pim_req_o && bus.pim_ready_i) begin
      psel_q.push_back(bus.pim_sel_o);
      if (bus.pim_we_o) begin
        pwr_a_q.push_back({21'd0, bus.pim_addr_o});
        pwr_d_q.push_back(bus.pim_wr_data_o);
      end else begin
        prd_a_q.push_back({21'd0, bus.pim_addr_o});
      end
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] all_outs();
    return {7'd0, bus.dma_busy_o, bus.mem_req_o, bus.mem_addr_o, bus.mem_wr_data_o,
            bus.mem_size_o, bus.mem_read_o, bus.mem_write_o, bus.pim_sel_o,
            bus.pim_req_o, bus.pim_we_o, bus.pim_addr_o, bus.pim_wr_data_o};
  endfunction

  task automatic clear_mon();
    mrd_q.delete(); mwr_a_q.delete(); mwr_d_q.delete();
    pwr_a_q.delete(); pwr_d_q.delete(); prd_a_q.delete(); psel_q.delete();
    busy_cyc = 0; overlap = 0; bad_size = 0;
  endtask

  task automatic issue(input logic [2:0] f3, input logic [3:0] sel,
                       input logic [12:0] size, input logic [31:0] addr);
    @(posedge clk_i); #1;
    bus.dma_funct3_i   = f3;
    bus.dma_sel_pim_i  = sel;
    bus.dma_size_i     = size;
    bus.dma_mem_addr_i = addr;
    bus.dma_en_i       = 1'b1;
    @(posedge clk_i); #1;
    bus.dma_en_i       = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (bus.dma_busy_o && n < 300) begin
      @(posedge clk_i); #1;
      n++;
    end
    check(tag, bus.dma_busy_o, 1'b0);
  endtask

  task automatic wait_pwr(input int cnt, input string tag);
    int n = 0;
    while (pwr_a_q.size() < cnt && n < 300) begin
      @(posedge clk_i); #1;
      n++;
    end
    check(tag, pwr_a_q.size() >= cnt, 1'b1);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i); #1;
    end
  endtask

  initial begin
    bus.dma_en_i       = 1'b0;
    bus.dma_funct3_i   = 3'b000;
    bus.dma_sel_pim_i  = 4'b0000;
    bus.dma_size_i     = 13'd0;
    bus.dma_mem_addr_i = 32'd0;
    bus.mem_gnt_i      = 1'b1;
    bus.pim_ready_i    = 1'b1;

    // Reset state
    @(negedge clk_i);
    check("reset_outputs", all_outs(), 128'd0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    idle_cycles(2);

    // MEM2PIM, 4 words from 0x2000_0000
    clear_mon();
    issue(DMA_M2P, 4'b0001, 13'd16, 32'h2000_0000);
    check("m2p_busy_rise", bus.dma_busy_o, 1'b1);
    wait_idle("m2p_idle");
    check("m2p_nreads", mrd_q.size(), 4);
    check("m2p_nwrites", pwr_a_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check("m2p_rd_addr", mrd_q[i], 32'h2000_0000 + 32'(4 * i));
      check("m2p_pim_addr", pwr_a_q[i], 32'(i));
      check("m2p_pim_data", pwr_d_q[i], 32'hFEAD_0000 + 32'(4 * i));
    end
    check("m2p_sel", psel_q[0], 4'b0001);
    check("m2p_busy_cycles", busy_cyc, 13);
    check("m2p_overlap", overlap, 0);

    // PIM2MEM, 2 words to 0x3000_0010
    clear_mon();
    issue(DMA_P2M, 4'b0010, 13'd8, 32'h3000_0010);
    check("p2m_busy_rise", bus.dma_busy_o, 1'b1);
    wait_idle("p2m_idle");
    check("p2m_nreads", prd_a_q.size(), 2);
    check("p2m_nwrites", mwr_a_q.size(), 2);
    for (int i = 0; i < 2; i++) begin
      check("p2m_pim_addr", prd_a_q[i], 32'(i));
      check("p2m_wr_addr", mwr_a_q[i], 32'h3000_0010 + 32'(4 * i));
      check("p2m_wr_data", mwr_d_q[i], 32'hCAFE_0000 + 32'(i));
    end
    check("p2m_sel", psel_q[0], 4'b0010);
    check("p2m_size", bad_size, 0);
    check("p2m_busy_cycles", busy_cyc, 5);
    check("p2m_overlap", overlap, 0);

    // Zero word count and illegal direction are dropped
    clear_mon();
    issue(DMA_M2P, 4'b0001, 13'd3, 32'h2000_0000);
    check("zero_busy", bus.dma_busy_o, 1'b0);
    issue(3'b111, 4'b0001, 13'd16, 32'h2000_0000);
    check("illegal_busy", bus.dma_busy_o, 1'b0);
    idle_cycles(4);
    check("drop_busy_cycles", busy_cyc, 0);
    check("drop_requests", mrd_q.size() + mwr_a_q.size() + psel_q.size(), 0);

    // Memory grant stall on word 1; size 14 truncates to 3 words
    clear_mon();
    issue(DMA_M2P, 4'b1000, 13'd14, 32'h1000_0100);
    wait_pwr(1, "gstall_first_word");
    bus.mem_gnt_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      check("gstall_hold", {bus.mem_req_o, bus.mem_read_o, bus.mem_size_o, bus.mem_addr_o},
            {1'b1, 1'b1, 4'b1111, 32'h1000_0104});
    end
    @(posedge clk_i); #1;
    bus.mem_gnt_i = 1'b1;
    wait_idle("gstall_idle");
    check("gstall_nreads", mrd_q.size(), 3);
    check("gstall_nwrites", pwr_a_q.size(), 3);
    for (int i = 0; i < 3; i++) begin
      check("gstall_rd_addr", mrd_q[i], 32'h1000_0100 + 32'(4 * i));
      check("gstall_pim_data", pwr_d_q[i], 32'hCEAD_0100 + 32'(4 * i));
    end
    check("gstall_busy_cycles", busy_cyc, 15);

    // PIM ready delayed 3 cycles on the first word
    clear_mon();
    bus.pim_ready_i = 1'b0;
    issue(DMA_P2M, 4'b0100, 13'd8, 32'h3000_0100);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check("rstall_hold", {bus.pim_req_o, bus.pim_we_o, bus.pim_addr_o, bus.mem_req_o},
            {1'b1, 1'b0, 11'd0, 1'b0});
    end
    @(posedge clk_i); #1;
    bus.pim_ready_i = 1'b1;
    wait_idle("rstall_idle");
    check("rstall_nwrites", mwr_a_q.size(), 2);
    check("rstall_wr_addr1", mwr_a_q[1], 32'h3000_0104);
    check("rstall_wr_data1", mwr_d_q[1], 32'hCAFE_0001);
    check("rstall_busy_cycles", busy_cyc, 8);

    // Address wrap at the top of memory
    clear_mon();
    issue(DMA_M2P, 4'b0001, 13'd8, 32'hFFFF_FFFC);
    wait_idle("wrap_idle");
    check("wrap_nreads", mrd_q.size(), 2);
    check("wrap_addr0", mrd_q[0], 32'hFFFF_FFFC);
    check("wrap_addr1", mrd_q[1], 32'h0000_0000);
    check("wrap_data1", pwr_d_q[1], 32'hDEAD_0000);

`ifdef PIM_DMA_STATS_EN
    check("stats_before_reset", bus.dma_done_cnt_o, 16'd5);
`endif

    // Reset mid-transfer after word 2 of 4
    clear_mon();
    issue(DMA_M2P, 4'b0001, 13'd16, 32'h4000_0000);
    wait_pwr(2, "rst_two_words");
    rst_ni = 1'b0;
    @(negedge clk_i);
    check("rst_outputs", all_outs(), 128'd0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    clear_mon();
    idle_cycles(6);
    check("rst_idle_busy", busy_cyc, 0);
    check("rst_no_requests", mrd_q.size() + mwr_a_q.size() + psel_q.size(), 0);

`ifdef PIM_DMA_STATS_EN
    check("stats_reset", bus.dma_done_cnt_o, 16'd0);
    for (int i = 0; i < 3; i++) begin
      issue(DMA_M2P, 4'b0001, 13'd4, 32'h5000_0000);
      wait_idle("stats_idle");
    end
    check("stats_three", bus.dma_done_cnt_o, 16'd3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
